// File: rtl/output_writer.sv
// ============================================================================
// output_writer: bias add, rounding shift, ReLU, int8 saturation, SRAM write-back
// Revision: 1.0
// ============================================================================
`default_nettype none

module output_writer #(
    parameter int ACC_W      = 32,
    parameter int OUT_BANKS  = 6,
    parameter int BANK_WORDS = 32768,
    parameter int BIAS_AW    = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [17:0]          num_words_i,
    input  logic [9:0]           num_ch_i,
    input  logic [4:0]           shift_i,
    input  logic                 relu_en_i,
    input  logic                 acc_valid_i,
    input  logic [ACC_W-1:0]     acc_data_i,
    output logic                 acc_ready_o,
    output logic                 bias_cs_o,
    output logic [BIAS_AW-1:0]   bias_addr_o,
    input  logic [15:0]          bias_rdata_i,
    output logic [OUT_BANKS-1:0] out_cs_o,
    output logic                 out_we_o,
    output logic [14:0]          out_addr_o,
    output logic [15:0]          out_wdata_o,
    output logic                 busy_o,
    output logic                 finish_o
);

    localparam int          ROW_W   = $clog2(BANK_WORDS);
    localparam logic [18:0] c_LIMIT = 19'(OUT_BANKS * BANK_WORDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [17:0]        num_words_q;
    logic [9:0]         num_ch_q;
    logic [4:0]         shift_q;
    logic               relu_q;
    logic [17:0]        acc_cnt_q;
    logic [9:0]         ch_q;
    logic [17:0]        widx_q;
    logic               s1_valid_q;
    logic [ACC_W-1:0]   s1_acc_q;
    logic               s2_valid_q;
    logic [7:0]         s2_q;
    logic [17:0]        s2_idx_q;

    logic               w_can_accept;
    logic               w_xfer;
    logic [ACC_W:0]     w_sum;
    logic [ACC_W+1:0]   w_sum_x;
    logic [ACC_W+1:0]   w_round;
    logic signed [ACC_W+1:0] w_tmp;
    logic signed [ACC_W+1:0] w_r;
    logic               w_neg;
    logic               w_hi_ones;
    logic               w_hi_zero;
    logic [7:0]         w_q;
    logic [17-ROW_W:0]  w_bank;
    logic               w_wr;

    assign w_can_accept = (state_q == S_RUN) && (acc_cnt_q < num_words_q) && !rst;
    assign w_xfer       = w_can_accept && acc_valid_i;

    // S1 datapath: bias arrives this cycle from the SRAM read issued at transfer.
    assign w_sum   = {s1_acc_q[ACC_W-1], s1_acc_q}
                   + {{(ACC_W-15){bias_rdata_i[15]}}, bias_rdata_i};
    assign w_sum_x = {w_sum[ACC_W], w_sum};
    // Half-LSB rounding constant; collapses to zero when shift is zero.
    assign w_round = ((ACC_W+2)'(1) << shift_q) >> 1;
    assign w_tmp   = w_sum_x + w_round;
    assign w_r     = w_tmp >>> shift_q;

    assign w_neg     = w_r[ACC_W+1];
    assign w_hi_ones = &w_r[ACC_W+1:7];
    assign w_hi_zero = ~|w_r[ACC_W+1:7];

    always_comb begin
        w_q = w_r[7:0];
        if (relu_q && w_neg) begin
            w_q = 8'h00;
        end else if (w_neg && !w_hi_ones) begin
            w_q = 8'h80;
        end else if (!w_neg && !w_hi_zero) begin
            w_q = 8'h7F;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = (num_words_i == 18'd0) ? S_DONE : S_RUN;
            S_RUN:   if (w_xfer && (acc_cnt_q + 18'd1 == num_words_q)) state_d = S_DRAIN;
            S_DRAIN: if (!s1_valid_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            num_words_q <= '0;
            num_ch_q    <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            acc_cnt_q   <= '0;
            ch_q        <= '0;
            widx_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_acc_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_q        <= '0;
            s2_idx_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start_i) begin
                num_words_q <= num_words_i;
                num_ch_q    <= (num_ch_i == 10'd0) ? 10'd1 : num_ch_i;
                shift_q     <= shift_i;
                relu_q      <= relu_en_i;
                acc_cnt_q   <= '0;
                ch_q        <= '0;
                widx_q      <= '0;
            end
            if (w_xfer) begin
                acc_cnt_q <= acc_cnt_q + 18'd1;
                ch_q      <= (ch_q == num_ch_q - 10'd1) ? 10'd0 : ch_q + 10'd1;
                s1_acc_q  <= acc_data_i;
            end
            s1_valid_q <= w_xfer;
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_q     <= w_q;
                s2_idx_q <= widx_q;
                widx_q   <= widx_q + 18'd1;
            end
        end
    end

    assign w_bank = s2_idx_q[17:ROW_W];
    // Out-of-range indices still consume an index but never strobe the SRAM.
    assign w_wr   = s2_valid_q && !rst && ({1'b0, s2_idx_q} < c_LIMIT);

    assign acc_ready_o = w_can_accept;
    assign bias_cs_o   = w_xfer;
    assign bias_addr_o = BIAS_AW'(ch_q);
    assign out_we_o    = w_wr;
    assign out_cs_o    = w_wr ? (OUT_BANKS'(1) << w_bank) : '0;
    assign out_addr_o  = w_wr ? s2_idx_q[14:0] : 15'd0;
    assign out_wdata_o = w_wr ? {{8{s2_q[7]}}, s2_q} : 16'd0;
    assign busy_o      = ((state_q == S_RUN) || (state_q == S_DRAIN)) && !rst;
    assign finish_o    = (state_q == S_DONE) && !rst;

endmodule

`default_nettype wire

// File: tb/tb_output_writer.sv
// ============================================================================
// tb_output_writer: vector table, randomized jobs and corner sequences vs a model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_output_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [17:0] num_words_i = '0;
    logic [9:0]  num_ch_i = '0;
    logic [4:0]  shift_i = '0;
    logic        relu_en_i = 1'b0;
    logic        acc_valid_i = 1'b0;
    logic [31:0] acc_data_i = '0;
    logic        acc_ready_o;
    logic        bias_cs_o;
    logic [9:0]  bias_addr_o;
    logic [15:0] bias_rdata_i = '0;
    logic [5:0]  out_cs_o;
    logic        out_we_o;
    logic [14:0] out_addr_o;
    logic [15:0] out_wdata_o;
    logic        busy_o;
    logic        finish_o;

    output_writer dut (
        .clk(clk), .rst(rst), .start_i(start_i), .num_words_i(num_words_i),
        .num_ch_i(num_ch_i), .shift_i(shift_i), .relu_en_i(relu_en_i),
        .acc_valid_i(acc_valid_i), .acc_data_i(acc_data_i), .acc_ready_o(acc_ready_o),
        .bias_cs_o(bias_cs_o), .bias_addr_o(bias_addr_o), .bias_rdata_i(bias_rdata_i),
        .out_cs_o(out_cs_o), .out_we_o(out_we_o), .out_addr_o(out_addr_o),
        .out_wdata_o(out_wdata_o), .busy_o(busy_o), .finish_o(finish_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [15:0] data;
        longint     c;
    } exp_t;

    typedef struct {
        int          acc;
        int          bias;
        int          sh;
        bit          relu;
        logic [15:0] exp;
    } vec_t;

    int          n_pass = 0;
    int          n_total = 0;
    longint      cyc = 0;
    exp_t        q_exp[$];
    int          drv_data[$];
    logic signed [15:0] bias_mem [1024];
    int          k_xfer, n_writes, n_finish, m_nch, m_shift;
    bit          m_relu;
    longint      last_wr_cyc, finish_cyc, start_cyc;
    logic [15:0] last_wdata;
    logic [5:0]  last_cs;
    logic [14:0] last_addr;
    logic [5:0]  cap_cs [3];
    logic [14:0] cap_addr [3];

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bias_cs_o) bias_rdata_i <= bias_mem[bias_addr_o];

    task automatic chk(input string name, input longint got, input longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic logic [15:0] ref_out(input longint acc, input longint bias,
                                            input int sh, input bit relu);
        longint s, r;
        s = acc + bias;
        if (sh > 0) r = (s + (longint'(1) << (sh - 1))) >>> sh;
        else        r = s;
        if (relu && r < 0) r = 0;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return 16'(r);
    endfunction

    function automatic logic [5:0] exp_cs(input int idx);
        if (idx < 6 * 32768) return 6'(1 << (idx / 32768));
        return 6'd0;
    endfunction

    // Observer: builds the expected write stream from accepted transfers.
    always @(negedge clk) begin
        if (rst) begin
            chk("we_during_reset", out_we_o, 0);
            q_exp.delete();
        end else begin
            if (acc_valid_i && acc_ready_o) begin
                exp_t e;
                chk("bias_cs", bias_cs_o, 1);
                chk("bias_addr", bias_addr_o, k_xfer % m_nch);
                e.idx  = k_xfer;
                e.data = ref_out(longint'($signed(acc_data_i)),
                                 longint'(bias_mem[k_xfer % m_nch]), m_shift, m_relu);
                e.c    = cyc;
                q_exp.push_back(e);
                k_xfer++;
            end
            if (out_we_o) begin
                if (q_exp.size() == 0) begin
                    chk("unexpected_write", out_we_o, 0);
                end else begin
                    exp_t e;
                    e = q_exp.pop_front();
                    chk("wr_latency", cyc, e.c + 2);
                    chk("out_cs", out_cs_o, exp_cs(e.idx));
                    chk("out_addr", out_addr_o, e.idx % 32768);
                    chk("out_wdata", out_wdata_o, e.data);
                    if (e.idx >= 32767 && e.idx <= 32769) begin
                        cap_cs[e.idx-32767]   = out_cs_o;
                        cap_addr[e.idx-32767] = out_addr_o;
                    end
                end
                last_wdata  = out_wdata_o;
                last_cs     = out_cs_o;
                last_addr   = out_addr_o;
                last_wr_cyc = cyc;
                n_writes++;
            end
            if (finish_o) begin
                n_finish++;
                finish_cyc = cyc;
                chk("busy_at_finish", busy_o, 0);
            end
        end
    end

    task automatic run_job(input int nw, input int nch, input int sh, input bit relu,
                           input int gap_pct, input int abort_at, input bit stray);
        int sent = 0;
        int guard = 0;
        int g = 0;
        int wr_at_abort;
        m_nch = (nch == 0) ? 1 : nch;
        m_shift = sh; m_relu = relu;
        k_xfer = 0; n_writes = 0; n_finish = 0;
        q_exp.delete();
        @(posedge clk); #1;
        num_words_i = 18'(nw); num_ch_i = 10'(nch); shift_i = 5'(sh); relu_en_i = relu;
        start_i = 1'b1; start_cyc = cyc;
        @(posedge clk); #1;
        start_i = 1'b0;
        if (nw > 0) chk("busy_after_start", busy_o, 1);
        while (sent < nw && guard < nw * 20 + 100) begin
            if (abort_at > 0 && sent == abort_at) break;
            guard++;
            if ($urandom_range(99) < gap_pct) begin
                acc_valid_i = 1'b0;
                @(posedge clk); #1;
            end else begin
                acc_valid_i = 1'b1;
                if (drv_data.size() > sent) acc_data_i = drv_data[sent];
                else if ($urandom_range(1) == 1) acc_data_i = $urandom;
                else acc_data_i = 32'($urandom_range(8000)) - 32'd4000;
                if (stray && $urandom_range(15) == 0) begin
                    start_i = 1'b1; num_words_i = 18'd3;
                end
                @(negedge clk);
                if (acc_ready_o) sent++;
                @(posedge clk); #1;
                start_i = 1'b0;
            end
        end
        if (abort_at > 0) begin
            rst = 1'b1; acc_valid_i = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            wr_at_abort = n_writes;
            repeat (6) begin
                @(negedge clk);
                chk("abort_we", out_we_o, 0);
                chk("abort_cs", out_cs_o, 0);
                chk("abort_wdata", out_wdata_o, 0);
                chk("abort_finish", finish_o, 0);
                chk("abort_busy", busy_o, 0);
                chk("abort_ready", acc_ready_o, 0);
            end
            chk("abort_no_new_writes", n_writes, wr_at_abort);
            chk("abort_no_finish", n_finish, 0);
        end else begin
            chk("all_sent", sent, nw);
            acc_valid_i = 1'b1;
            repeat (3) begin
                @(negedge clk);
                chk("ready_after_last", acc_ready_o, 0);
                @(posedge clk); #1;
            end
            acc_valid_i = 1'b0;
            while (n_finish == 0 && g < 40) begin
                @(posedge clk); #1;
                g++;
            end
            repeat (3) @(posedge clk);
            #1;
            chk("finish_pulses", n_finish, 1);
            chk("write_count", n_writes, nw);
            chk("queue_drained", q_exp.size(), 0);
            chk("idle_after_finish", busy_o, 0);
            if (nw > 0) chk("finish_timing", finish_cyc, last_wr_cyc + 1);
            else        chk("zero_finish_timing", finish_cyc, start_cyc + 1);
        end
        drv_data.delete();
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{10, 5, 0, 0, 16'h000F};
        vecs[1]  = '{32'h7FFFFFFF, 0, 4, 0, 16'h007F};
        vecs[2]  = '{-24, 0, 4, 0, 16'hFFFF};
        vecs[3]  = '{int'(32'h80000000), 0, 4, 0, 16'hFF80};
        vecs[4]  = '{32'h7FFFFFFF, 0, 4, 1, 16'h007F};
        vecs[5]  = '{-24, 0, 4, 1, 16'h0000};
        vecs[6]  = '{int'(32'h80000000), 0, 4, 1, 16'h0000};
        vecs[7]  = '{3, 0, 1, 0, 16'h0002};
        vecs[8]  = '{-3, 0, 1, 0, 16'hFFFF};
        vecs[9]  = '{50, -200, 0, 0, 16'hFF80};
        vecs[10] = '{-5, 3, 0, 0, 16'hFFFE};
        vecs[11] = '{100, 27, 0, 0, 16'h007F};
        vecs[12] = '{-40, 8, 5, 0, 16'hFFFF};
        vecs[13] = '{24, 0, 4, 0, 16'h0002};
        for (int i = 0; i < 1024; i++) bias_mem[i] = 16'sd0;
        m_nch = 1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", acc_ready_o, 0);
        chk("rst_bias_cs", bias_cs_o, 0);
        chk("rst_bias_addr", bias_addr_o, 0);
        chk("rst_out_cs", out_cs_o, 0);
        chk("rst_we", out_we_o, 0);
        chk("rst_addr", out_addr_o, 0);
        chk("rst_wdata", out_wdata_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_finish", finish_o, 0);

        for (int i = 0; i < 14; i++) begin
            bias_mem[0] = 16'(vecs[i].bias);
            drv_data.push_back(vecs[i].acc);
            run_job(1, 1, vecs[i].sh, vecs[i].relu, 0, 0, 0);
            chk($sformatf("vec%0d_wdata", i), last_wdata, vecs[i].exp);
            if (i == 0) begin
                chk("basic_cs", last_cs, 6'b000001);
                chk("basic_addr", last_addr, 0);
            end
        end

        bias_mem[0] = 16'sd1; bias_mem[1] = 16'sd2; bias_mem[2] = 16'sd3;
        for (int i = 0; i < 7; i++) drv_data.push_back(i * 10 - 30);
        run_job(7, 3, 0, 0, 0, 0, 0);

        for (int i = 0; i < 1024; i++) bias_mem[i] = 16'($urandom);
        run_job(100, 1 + $urandom_range(16), $urandom_range(31), 1'($urandom), 30, 0, 1);
        run_job(100, 0, $urandom_range(8), 1'b0, 40, 0, 1);
        run_job(100, 1 + $urandom_range(999), $urandom_range(12), 1'b1, 25, 0, 1);
        run_job(0, 4, 0, 0, 0, 0, 0);

        run_job(20, 5, 2, 0, 0, 10, 0);
        run_job(20, 5, 2, 0, 0, 0, 0);

        run_job(32770, 7, $urandom_range(10), 1'b0, 0, 0, 0);
        chk("bank_w32767_cs", cap_cs[0], 6'b000001);
        chk("bank_w32767_addr", cap_addr[0], 15'h7FFF);
        chk("bank_w32768_cs", cap_cs[1], 6'b000010);
        chk("bank_w32768_addr", cap_addr[1], 15'h0000);
        chk("bank_w32769_cs", cap_cs[2], 6'b000010);
        chk("bank_w32769_addr", cap_addr[2], 15'h0001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
